// File: rtl/hazard_scoreboard_unit_if.sv
// Bundle between the pipeline control path and hazard_scoreboard_unit.
// Carries the ID-stage instruction description, the EX redirect / hold /
// long-unit completion controls, and every stall/flush/forward result.
//
// Handshake contract: there is no valid/ready pair; id_valid qualifies the
// ID fields in the same cycle, and while stall_if is high the pipeline keeps
// presenting the same ID instruction until it issues or is flushed.
interface hazard_scoreboard_unit_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
);
    logic              hold;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic [1:0]        id_class;
    logic              id_is_jal;
    logic              ex_redirect;
    logic              long_done;
    logic [REG_AW-1:0] long_done_rd;

    logic              stall_if;
    logic              flush_if;
    logic              flush_id;
    logic              flush_ex;
    logic [1:0]        fwd_rs1_ex;
    logic [1:0]        fwd_rs2_ex;
    logic              fwd_rs1_id;
    logic              fwd_rs2_id;
    logic              long_busy;
    logic [PERF_W-1:0] perf_stall_cnt;
    logic [PERF_W-1:0] perf_flush_cnt;

    // Pipeline side: drives the instruction/control inputs.
    modport master (
        output hold, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_class, id_is_jal, ex_redirect,
               long_done, long_done_rd,
        input  stall_if, flush_if, flush_id, flush_ex, fwd_rs1_ex,
               fwd_rs2_ex, fwd_rs1_id, fwd_rs2_id, long_busy,
               perf_stall_cnt, perf_flush_cnt
    );

    // Hazard unit side.
    modport slave (
        input  hold, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_class, id_is_jal, ex_redirect,
               long_done, long_done_rd,
        output stall_if, flush_if, flush_id, flush_ex, fwd_rs1_ex,
               fwd_rs2_ex, fwd_rs1_id, fwd_rs2_id, long_busy,
               perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard / forwarding controller for the 5-stage pipeline.
// Per-register scoreboard of pending writes (countdown for loads, all-ones
// sentinel for long ops), shadow copy of EX/MEM/WB destinations for
// forwarding selects, and stall/flush arbitration.
// Optional feature macro: HZ_PERF_CNT_EN enables the performance counters;
// without it both counter ports are tied to zero.
module hazard_scoreboard_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 3,
    parameter int PERF_W   = 32
) (
    input logic                    clk,
    input logic                    rstn,
    hazard_scoreboard_unit_if.slave hz
);
    localparam int              NREG   = 1 << REG_AW;
    localparam logic [CNT_W-1:0] SENT   = '1;
    localparam logic [CNT_W-1:0] LD_CNT = CNT_W'(LOAD_LAT);

    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_LONG = 2'd2;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              we;
    } ex_slot_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              we;
    } dst_slot_t;

    logic [CNT_W-1:0] sb [NREG];
    logic             long_busy_q;
    ex_slot_t         ex_q;
    dst_slot_t        mem_q;
    dst_slot_t        wb_q;

    logic             rs1_used, rs2_used, dst_nz, is_long;
    logic             dh, issue;
    logic [CNT_W-1:0] issue_cnt;
    logic             flush_if_c;

    assign rs1_used = hz.id_rs1_used && (hz.id_rs1 != '0);
    assign rs2_used = hz.id_rs2_used && (hz.id_rs2 != '0);
    assign dst_nz   = hz.id_reg_write && (hz.id_rd != '0);
    assign is_long  = (hz.id_class == CLS_LONG);

    // Data hazard: pending source, WAW against a long op, or long unit busy.
    assign dh = hz.id_valid &&
                ((rs1_used && sb[hz.id_rs1] != '0) ||
                 (rs2_used && sb[hz.id_rs2] != '0) ||
                 (dst_nz && sb[hz.id_rd] == SENT) ||
                 (is_long && long_busy_q));

    assign issue = hz.id_valid && !hz.hold && !hz.ex_redirect && !dh;

    // Scoreboard value written for the issuing instruction's destination.
    always_comb begin
        issue_cnt = '0;
        case (hz.id_class)
            CLS_LOAD: issue_cnt = LD_CNT;
            CLS_LONG: issue_cnt = SENT;
            default:  issue_cnt = '0;
        endcase
    end

    // One scoreboard entry per register: countdown, long_done clear, issue write (last wins).
    for (genvar g = 0; g < NREG; g++) begin : g_sb
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sb[g] <= '0;
            end else begin
                if (!hz.hold && sb[g] != '0 && sb[g] != SENT)
                    sb[g] <= sb[g] - CNT_W'(1);
                if (hz.long_done && hz.long_done_rd == REG_AW'(g))
                    sb[g] <= '0;
                if (issue && dst_nz && hz.id_rd == REG_AW'(g))
                    sb[g] <= issue_cnt;
            end
        end
    end

    // Long unit occupancy: completion clears even under hold, a new long issue sets.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            long_busy_q <= 1'b0;
        else if (issue && is_long)
            long_busy_q <= 1'b1;
        else if (hz.long_done)
            long_busy_q <= 1'b0;
    end

    // Shadow pipe of issued instructions; long ops never forward so they carry we=0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!hz.hold) begin
            if (issue) begin
                ex_q.rs1 <= hz.id_rs1;
                ex_q.rs2 <= hz.id_rs2;
                ex_q.rd  <= hz.id_rd;
                ex_q.we  <= hz.id_reg_write && !is_long;
            end else begin
                ex_q <= '0;
            end
            mem_q <= '{rd: ex_q.rd, we: ex_q.we};
            wb_q  <= mem_q;
        end
    end

    function automatic logic hit(input dst_slot_t s, input logic [REG_AW-1:0] src);
        return s.we && (s.rd != '0) && (s.rd == src);
    endfunction

    function automatic logic [1:0] ex_sel(input dst_slot_t m, input dst_slot_t w,
                                          input logic [REG_AW-1:0] src);
        if (hit(m, src))      return 2'b01;
        else if (hit(w, src)) return 2'b10;
        else                  return 2'b00;
    endfunction

    // Output arbitration: hold > redirect > data hazard > JAL; all zero in reset.
    always_comb begin
        hz.stall_if   = 1'b0;
        hz.flush_if   = 1'b0;
        hz.flush_id   = 1'b0;
        hz.flush_ex   = 1'b0;
        hz.fwd_rs1_ex = 2'b00;
        hz.fwd_rs2_ex = 2'b00;
        hz.fwd_rs1_id = 1'b0;
        hz.fwd_rs2_id = 1'b0;
        hz.long_busy  = 1'b0;
        if (rstn) begin
            if (hz.hold) begin
                hz.stall_if = 1'b1;
            end else if (hz.ex_redirect) begin
                hz.flush_if = 1'b1;
                hz.flush_id = 1'b1;
            end else if (dh) begin
                hz.stall_if = 1'b1;
                hz.flush_ex = 1'b1;
            end else if (hz.id_is_jal) begin
                hz.flush_if = 1'b1;
            end
            hz.fwd_rs1_ex = ex_sel(mem_q, wb_q, ex_q.rs1);
            hz.fwd_rs2_ex = ex_sel(mem_q, wb_q, ex_q.rs2);
            hz.fwd_rs1_id = hit(wb_q, hz.id_rs1);
            hz.fwd_rs2_id = hit(wb_q, hz.id_rs2);
            hz.long_busy  = long_busy_q;
        end
    end

    assign flush_if_c = rstn && !hz.hold && (hz.ex_redirect || (!dh && hz.id_is_jal));

`ifdef HZ_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    // Performance counters: data-hazard stall cycles and IF flush events, wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (dh && !hz.hold && !hz.ex_redirect)
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            if (flush_if_c)
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
        end
    end

    assign hz.perf_stall_cnt = stall_cnt_q;
    assign hz.perf_flush_cnt = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf       = flush_if_c;
    assign hz.perf_stall_cnt = '0;
    assign hz.perf_flush_cnt = '0;
`endif

endmodule
